// File: rtl/multdiv_issue_ctrl.sv
// Issue/writeback sequencer for the multi-cycle multdiv unit: holds one MULT/DIV,
// stalls the pipe, pulses the unit once, then emits a single writeback beat.
module multdiv_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int RSTATUS_REG    = 30,
    parameter int MULT_EXC_CODE  = 4,
    parameter int DIV_EXC_CODE   = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd_in,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        timeout_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic           op_div;
    logic [4:0]     rd_q;
    logic [31:0]    res_q;
    logic           exc_q;
    logic           start_any;
    logic           timed_out;

    assign start_any = start_mult | start_div;
    // Last WAIT cycle without RDY: the counter is about to reach the limit.
    assign timed_out = (state == S_WAIT) && !md_resultRDY
                       && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_any) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (md_resultRDY || timed_out) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_operandA <= '0;
            md_operandB <= '0;
            rd_q        <= '0;
            op_div      <= 1'b0;
            cnt         <= '0;
            res_q       <= '0;
            exc_q       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start_any) begin
                    md_operandA <= operand_a;
                    md_operandB <= operand_b;
                    rd_q        <= rd_in;
                    op_div      <= !start_mult;
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    if (cnt != CW'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
                    if (md_resultRDY) begin
                        res_q <= md_result;
                        exc_q <= md_exception;
                    end else if (timed_out) begin
                        exc_q       <= 1'b1;
                        timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        md_ctrl_MULT = (state == S_ISSUE) && !op_div;
        md_ctrl_DIV  = (state == S_ISSUE) && op_div;
        stall        = ((state == S_IDLE) && start_any) || (state == S_ISSUE)
                       || (state == S_WAIT);
        wb_valid     = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        if (state == S_DONE) begin
            // Clean results headed for r0 are dropped; exceptions always land.
            wb_valid = exc_q || (rd_q != 5'd0);
            wb_rd    = exc_q ? 5'(RSTATUS_REG) : rd_q;
            wb_data  = exc_q ? (op_div ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE)) : res_q;
        end
    end
endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Bench for multdiv_issue_ctrl: spec vectors, reset/back-to-back sequences and
// randomized ops, with a behavioural multdiv responder and a cycle-count reference.
module tb_multdiv_issue_ctrl;
    localparam int TO = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_mult, start_div;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  rd_in;
    logic [31:0] md_operandA, md_operandB;
    logic        md_ctrl_MULT, md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception, md_resultRDY;
    logic        stall, wb_valid, timeout_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    multdiv_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          mult;
        bit          div;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          n;      // RDY delay after the pulse; 0 = never
        bit          exc;
        bit          early;  // spurious RDY during the issue cycle
        int          tail;   // idle cycles after DONE
        bit          exp_wbv;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        int          exp_done;
        bit          exp_to;
    } vec_t;

    int tests = 0;
    int fails = 0;
    bit to_model = 1'b0;

    int          obs_pm, obs_pd, obs_pcyc, obs_stall, obs_wbv, obs_wb_cyc, obs_opbad;
    logic [31:0] obs_opa, obs_opb, obs_wb_data;
    logic [4:0]  obs_wb_rd;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] calc_result(input vec_t v);
        if (v.mult)      return v.a * v.b;
        else if (v.b == 0) return 32'hDEAD_BEEF;
        else             return v.a / v.b;
    endfunction

    // Reference: derive latency and writeback directly from the timing rules.
    function automatic vec_t ref_fill(input vec_t v, input bit to_prev);
        bit tmo, exc_eff;
        vec_t r = v;
        tmo        = !(v.n >= 1 && v.n <= TO);
        exc_eff    = tmo || v.exc;
        r.exp_done = tmo ? TO + 2 : v.n + 2;
        r.exp_rd   = exc_eff ? 5'd30 : v.rd;
        r.exp_data = exc_eff ? (v.mult ? 32'd4 : 32'd5) : calc_result(v);
        r.exp_wbv  = exc_eff || (v.rd != 0);
        r.exp_to   = to_prev || tmo;
        return r;
    endfunction

    task automatic run_op(input vec_t v);
        int pc = -1;
        bit hold;
        logic [31:0] res = calc_result(v);
        obs_pm = 0; obs_pd = 0; obs_pcyc = -1; obs_stall = 0; obs_wbv = 0;
        obs_wb_cyc = -1; obs_opbad = 0; obs_opa = '0; obs_opb = '0;
        obs_wb_rd = '0; obs_wb_data = '0;
        for (int c = 0; c <= v.exp_done + v.tail; c++) begin
            @(posedge clock); #1;
            hold       = (c <= v.exp_done);
            start_mult = hold && v.mult;
            start_div  = hold && v.div;
            operand_a  = hold ? v.a : $urandom;
            operand_b  = hold ? v.b : $urandom;
            rd_in      = hold ? v.rd : 5'($urandom);
            if (pc >= 0 && v.n > 0 && c == pc + v.n) begin
                md_resultRDY = 1'b1; md_result = res; md_exception = v.exc;
            end else begin
                md_resultRDY = v.early && (c == 1);
                md_result    = $urandom;
                md_exception = 1'($urandom_range(0, 1));
            end
            #3;
            if (stall) obs_stall++;
            if (md_ctrl_MULT) obs_pm++;
            if (md_ctrl_DIV)  obs_pd++;
            if ((md_ctrl_MULT || md_ctrl_DIV) && pc < 0) begin
                pc = c; obs_pcyc = c; obs_opa = md_operandA; obs_opb = md_operandB;
            end
            if (pc >= 0 && c <= v.exp_done && (md_operandA != v.a || md_operandB != v.b))
                obs_opbad++;
            if (wb_valid) begin
                obs_wbv++; obs_wb_cyc = c; obs_wb_rd = wb_rd; obs_wb_data = wb_data;
            end
        end
        start_mult = 1'b0; start_div = 1'b0; md_resultRDY = 1'b0;
    endtask

    task automatic check_op(input string tag, input vec_t v);
        chk({tag, " mult_pulses"}, obs_pm, v.mult ? 1 : 0);
        chk({tag, " div_pulses"}, obs_pd, v.mult ? 0 : 1);
        chk({tag, " pulse_cycle"}, obs_pcyc, 1);
        chk({tag, " opA"}, obs_opa, v.a);
        chk({tag, " opB"}, obs_opb, v.b);
        chk({tag, " operand_hold"}, obs_opbad, 0);
        chk({tag, " stall_cycles"}, obs_stall, v.exp_done);
        chk({tag, " wb_count"}, obs_wbv, v.exp_wbv ? 1 : 0);
        if (v.exp_wbv) begin
            chk({tag, " wb_cycle"}, obs_wb_cyc, v.exp_done);
            chk({tag, " wb_rd"}, obs_wb_rd, v.exp_rd);
            chk({tag, " wb_data"}, obs_wb_data, v.exp_data);
        end
        chk({tag, " timeout_err"}, timeout_err, v.exp_to);
    endtask

    vec_t tbl[10];
    vec_t v;
    int   extra;

    initial begin
        //           mult div a             b     rd  n   exc ea tl wbv rd  data          done to
        tbl[0] = '{1, 0, 32'd7,         32'd6,   5'd5,  2,  0, 0, 2, 1, 5'd5,  32'd42,        4,  0};
        tbl[1] = '{0, 1, 32'd9,         32'd0,   5'd8,  5,  1, 0, 2, 1, 5'd30, 32'd5,         7,  0};
        tbl[2] = '{1, 1, 32'd3,         32'd4,   5'd9,  2,  0, 0, 2, 1, 5'd9,  32'd12,        4,  0};
        tbl[3] = '{1, 0, 32'd5,         32'd5,   5'd0,  3,  0, 0, 0, 0, 5'd0,  32'd0,         5,  0};
        tbl[4] = '{0, 1, 32'd10,        32'd3,   5'd2,  4,  0, 0, 2, 1, 5'd2,  32'd3,         6,  0};
        tbl[5] = '{1, 0, 32'hFFFF_FFFF, 32'd2,   5'd7,  1,  0, 1, 2, 1, 5'd7,  32'hFFFF_FFFE, 3,  0};
        tbl[6] = '{1, 0, 32'd1234,      32'd99,  5'd3,  6,  1, 0, 2, 1, 5'd30, 32'd4,         8,  0};
        tbl[7] = '{0, 1, 32'd100,       32'd7,   5'd31, 40, 0, 0, 2, 1, 5'd31, 32'd14,        42, 0};
        tbl[8] = '{0, 1, 32'd20,        32'd4,   5'd4,  0,  0, 0, 2, 1, 5'd30, 32'd5,         42, 1};
        tbl[9] = '{1, 0, 32'd6,         32'd7,   5'd1,  0,  0, 0, 2, 1, 5'd30, 32'd4,         42, 1};

        reset = 1'b1; start_mult = 0; start_div = 0; operand_a = 0; operand_b = 0;
        rd_in = 0; md_result = 0; md_exception = 0; md_resultRDY = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset outputs", {md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
                              stall, wb_valid, wb_rd, wb_data, timeout_err}, 0);
        @(posedge clock); #1 reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i]);
            check_op($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset during WAIT of a mult: everything clears at once.
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            start_mult = (c < 3); operand_a = 32'd7; operand_b = 32'd6; rd_in = 5'd5;
            md_resultRDY = 1'b0;
            if (c == 3) reset = 1'b1;
            #3;
        end
        chk("midreset outputs", {md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
                                 stall, wb_valid, wb_rd, wb_data}, 0);
        chk("midreset timeout_err", timeout_err, 0);
        @(posedge clock); #1 reset = 1'b0;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #3;
            if (wb_valid || md_ctrl_MULT || md_ctrl_DIV) extra++;
        end
        chk("postreset quiet", extra, 0);
        to_model = 1'b0;
        v = ref_fill(tbl[0], to_model);
        run_op(v);
        check_op("postreset op", v);

        for (int i = 0; i < 30; i++) begin
            int r;
            v = tbl[0];
            v.mult  = 1'($urandom_range(0, 1));
            v.div   = 1'($urandom_range(0, 1));
            if (!v.mult && !v.div) v.div = 1'b1;
            v.a     = $urandom;
            v.b     = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
            v.rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            r       = $urandom_range(0, 9);
            v.n     = (r == 0) ? 0 : (r == 1) ? $urandom_range(38, 42) : $urandom_range(1, 6);
            v.exc   = (!v.mult && v.b == 0) ? 1'b1 : ($urandom_range(0, 9) == 0);
            v.early = 1'($urandom_range(0, 1));
            v.tail  = $urandom_range(0, 2);
            v = ref_fill(v, to_model);
            run_op(v);
            check_op($sformatf("rand%0d", i), v);
            to_model = v.exp_to;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
